// File: rtl/mem_arbiter_pkg.sv
// Shared types and parameter defaults for the fetch/data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int WAIT_MAX_DEF = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arbState_t;

  // Which requester owned the most recently completed transaction.
  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } arbPort_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-port memory request bus between the arbiter and the memory.
// Latency: n/a (wires only).
// Backpressure: the master holds MemReq and its operands until MemAck is seen.
// Ports: master drives MemReq/MemWe/MemAddr/MemWdata and receives MemRdata/MemAck;
//        slave is the mirror image.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic [DATA_W-1:0] MemRdata;
  logic              MemAck;

  modport master (
    output MemReq, MemWe, MemAddr, MemWdata,
    input  MemRdata, MemAck
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemWdata,
    output MemRdata, MemAck
  );

endinterface

// File: rtl/arb_wait_counter.sv
// Counts cycles a granted memory transaction has waited for MemAck.
// Latency: termCnt is combinational; it is high in the WAIT_MAX-th enabled cycle.
// Backpressure: none; clear has priority over enable.
// Ports: clk, reset (sync, active-high), clear (grant), enable (waiting cycle),
//        termCnt (this waiting cycle is the last one allowed).
module arb_wait_counter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic termCnt
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Firing on WAIT_MAX-1 means the count reaches WAIT_MAX on this very cycle,
  // so the FSM leaves the wait state after exactly WAIT_MAX unacked cycles.
  assign termCnt = enable && (count == CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one single-port memory bus.
// Latency: grant-to-Ready = ack latency + 1; one idle cycle after each Ready.
// Backpressure: requesters stall (StallArbF/M) until their one-cycle Ready pulse.
// Ports: clk, reset (sync, active-high); fetch port IReqF/IAddrF -> IRdataF/IReadyF;
//        data port DReqM/DWeM/DAddrM/DWdataM -> DRdataM/DReadyM; mem (master bus);
//        StallArbF/StallArbM to the hazard unit; MemErr sticky timeout flag.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IReqF,
  input  logic [ADDR_W-1:0] IAddrF,
  output logic [DATA_W-1:0] IRdataF,
  output logic              IReadyF,
  input  logic              DReqM,
  input  logic              DWeM,
  input  logic [ADDR_W-1:0] DAddrM,
  input  logic [DATA_W-1:0] DWdataM,
  output logic [DATA_W-1:0] DRdataM,
  output logic              DReadyM,
  mem_arbiter_if.master     mem,
  output logic              StallArbF,
  output logic              StallArbM,
  output logic              MemErr
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } memCmd_t;

  arbState_t state;
  arbPort_t  lastPort;
  memCmd_t   cmd;
  logic      memReq;

  logic fetchElig, dataElig, pickData, busy, grant, timeout, keep;

  // A port whose Ready is high was just served; do not re-issue it.
  assign fetchElig = IReqF & ~IReadyF;
  assign dataElig  = DReqM & ~DReadyM;
  // Data normally wins; right after a data completion a waiting fetch goes first.
  assign pickData  = dataElig & ~(fetchElig & (lastPort == PORT_DATA));
  assign busy      = (state == FETCH) || (state == DATA);
  assign grant     = (state == IDLE) && (fetchElig || dataElig);
  // A requester that dropped Req mid-flight gets neither data nor Ready.
  assign keep      = (state == FETCH) ? IReqF : DReqM;

  assign StallArbF = IReqF & ~IReadyF;
  assign StallArbM = DReqM & ~DReadyM;

  assign mem.MemReq   = memReq;
  assign mem.MemWe    = cmd.we;
  assign mem.MemAddr  = cmd.addr;
  assign mem.MemWdata = cmd.wdata;

  arb_wait_counter #(.WAIT_MAX(WAIT_MAX)) waitCnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant),
    .enable  (busy & ~mem.MemAck),
    .termCnt (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lastPort <= PORT_FETCH;
      cmd      <= '0;
      memReq   <= 1'b0;
      IReadyF  <= 1'b0;
      DReadyM  <= 1'b0;
      IRdataF  <= '0;
      DRdataM  <= '0;
      MemErr   <= 1'b0;
    end else begin
      IReadyF <= 1'b0;
      DReadyM <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            memReq <= 1'b1;
            if (pickData) begin
              state <= DATA;
              cmd   <= '{we: DWeM, addr: DAddrM, wdata: DWdataM};
            end else begin
              state <= FETCH;
              cmd   <= '{we: 1'b0, addr: IAddrF, wdata: cmd.wdata};
            end
          end
        end
        FETCH, DATA: begin
          // timeout is only raised in cycles without MemAck, so ack wins a tie.
          if (mem.MemAck || timeout) begin
            memReq   <= 1'b0;
            state    <= RESP;
            lastPort <= (state == DATA) ? PORT_DATA : PORT_FETCH;
            if (!mem.MemAck) begin
              MemErr <= 1'b1;
            end
            if (state == FETCH) begin
              if (keep) begin
                IReadyF <= 1'b1;
                IRdataF <= mem.MemAck ? mem.MemRdata : '0;
              end
            end else if (keep) begin
              DReadyM <= 1'b1;
              if (!cmd.we) begin
                DRdataM <= mem.MemAck ? mem.MemRdata : '0;
              end
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width.
REQ-002 Parameter: DATA_W, 32, data width.
REQ-003 Parameter: WAIT_MAX, 255, max cycles a memory transaction may wait for MemAck.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 IReqF  input  1  fetch-stage read request.
REQ-008 IAddrF  input  ADDR_W  fetch address.
REQ-009 IRdataF  output  DATA_W  fetched instruction word.
REQ-010 IReadyF  output  1  one-cycle fetch-completion pulse.
REQ-011 DReqM  input  1  memory-stage access request (lw/sw).
REQ-012 DWeM  input  1  1 = store, 0 = load.
REQ-013 DAddrM  input  ADDR_W  data address.
REQ-014 DWdataM  input  DATA_W  store data.
REQ-015 DRdataM  output  DATA_W  load data.
REQ-016 DReadyM  output  1  one-cycle data-completion pulse.
REQ-017 MemReq, MemWe, MemAddr, MemWdata  output  1/1/ADDR_W/DATA_W  single-port memory request bus.
REQ-018 MemRdata  input  DATA_W; MemAck  input  1  memory completion.
REQ-019 StallArbF, StallArbM  output  1  stall requests to the hazard unit.
REQ-020 MemErr  output  1  sticky timeout flag.

Function
REQ-021 FSM states: IDLE, FETCH, DATA, RESP.
REQ-022 IDLE: grant DATA if DReqM eligible, else FETCH if IReqF eligible, else stay; the grant latches address/we/wdata.
REQ-023 Tie-break: if both are eligible and the last completed transaction was DATA, grant FETCH (no starvation).
REQ-024 A port is ineligible in any cycle in which its Ready output is high (no re-issue of a just-served request).
REQ-025 FETCH/DATA: MemReq=1 with latched MemAddr/MemWe/MemWdata held stable until MemAck is sampled 1; MemWe=0 in FETCH.
REQ-026 Cycle MemAck=1: capture MemRdata into the granted port's data register; next state RESP.
REQ-027 RESP: the granted port's Ready=1 for exactly one cycle; next state IDLE. Grant-to-Ready latency = ack latency + 1; a new grant follows RESP by one cycle.
REQ-028 IRdataF/DRdataM hold their value until that port's next completion; DRdataM is unchanged by stores.
REQ-029 StallArbF = IReqF & ~IReadyF; StallArbM = DReqM & ~DReadyM (combinational).
REQ-030 Requesters hold Req and operands until Ready; an in-flight transaction is never aborted by Req falling, and its result is discarded silently.
REQ-031 Wait counter: cleared on grant, +1 each FETCH/DATA cycle without MemAck; on reaching WAIT_MAX, drop MemReq, set MemErr, load data register with 0, enter RESP.
REQ-032 MemAck outside FETCH/DATA SHALL be ignored.

Reset
REQ-033 While reset=1: state IDLE, MemReq=0, MemWe=0, MemAddr=0, MemWdata=0, IReadyF=0, DReadyM=0, IRdataF=0, DRdataM=0, MemErr=0, wait counter=0, last-grant=FETCH.
REQ-034 Reset mid-transaction: MemReq is low in the cycle after reset is sampled; the in-flight result is lost; no Ready pulse.

Structure
REQ-035 Package mem_arbiter_pkg SHALL hold the state enum and the ADDR_W/DATA_W/WAIT_MAX defaults.
REQ-036 The wait counter SHALL be sub-module arb_wait_counter (clear, enable, terminal-count output).

Verification
REQ-037 Fetch only, IAddrF=0x00400000, MemAck after 2 cycles, MemRdata=0x8C080004 -> IReadyF pulses 3 cycles after grant, IRdataF=0x8C080004, StallArbF low in the Ready cycle.
REQ-038 IReqF and DReqM (load, 0x10010000) raised together -> DATA granted first, DReadyM pulse, then FETCH granted, IReadyF pulse; no duplicate data access.
REQ-039 Store DWeM=1, DWdataM=0xDEADBEEF -> MemWe=1, MemWdata stable until MemAck; DRdataM unchanged.
REQ-040 MemAck never asserted, WAIT_MAX=4 -> MemReq drops after 4 wait cycles, MemErr=1 (sticky), Ready pulse with data 0.
REQ-041 Reset asserted 1 cycle after grant -> MemReq=0 next cycle, no Ready pulse, all outputs at reset values.
